// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch/execute sequencer and the Thumb-subset decoder.
package fetch_sequencer_pkg;

  // Sequencer states
  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDecode  = 3'd2,
    StExecute = 3'd3,
    StMem     = 3'd4,
    StFault   = 3'd5
  } seq_state_e;

  // Sequential PC step: one halfword instruction
  localparam int unsigned PcIncr       = 2;
  // Branch targets are relative to the instruction address plus the pipeline offset
  localparam int unsigned BranchOffset = 4;

  // Micro-op encodings produced by Decode
  typedef enum logic [3:0] {
    UopAdd    = 4'd0,
    UopSub    = 4'd1,
    UopCmp    = 4'd2,
    UopEor    = 4'd3,
    UopLsl    = 4'd4,
    UopMovImm = 4'd5,
    UopLdr    = 4'd6,
    UopStr    = 4'd7,
    UopB      = 4'd8,
    UopBcc    = 4'd9,
    UopUndef  = 4'd10
  } uop_e;

endpackage

// File: rtl/fetch_sequencer.sv
// Multi-cycle control sequencer: owns the PC, fetches halfword instructions over a
// req/ack handshake, holds the instruction register and sequences execute, memory
// and writeback cycles, including branch redirects and a sticky undefined-op fault.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int unsigned         ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [15:0]       instruction,
  input  logic              dec_undef,
  input  logic              dec_is_branch,
  input  logic              branch_taken,
  input  logic [31:0]       dec_num,
  input  logic              dec_is_load,
  input  logic              dec_is_store,
  input  logic              dec_writes_reg,
  input  logic              dec_sets_flags,
  output logic              mem_start,
  input  logic              mem_done,
  output logic              reg_we,
  output logic              flags_we,
  output logic [ADDR_W-1:0] pc,
  output logic              fault,
  output logic [31:0]       retired
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       instr_q, instr_d;
  logic [31:0]       retired_q, retired_d;
  logic              fault_q, fault_d;

  logic [ADDR_W-1:0] br_off;
  logic [ADDR_W-1:0] pc_seq;
  logic [ADDR_W-1:0] pc_br;
  seq_state_e        after_retire;

  // Halfword offset scaled to bytes, sign-extended/truncated to the PC width
  assign br_off       = ADDR_W'(signed'({dec_num, 1'b0}));
  assign pc_seq       = pc_q + ADDR_W'(PcIncr);
  assign pc_br        = pc_q + ADDR_W'(BranchOffset) + br_off;
  // run is only sampled at instruction completion
  assign after_retire = run ? StFetch : StIdle;

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign fault       = fault_q;
  assign retired     = retired_q;

  // Next-state, architectural updates and per-cycle strobes
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    fault_d   = fault_q;
    imem_req  = 1'b0;
    mem_start = 1'b0;
    reg_we    = 1'b0;
    flags_we  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StFetch;
      end
      StFetch: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = StDecode;
        end
      end
      StDecode: begin
        state_d = StExecute;
      end
      StExecute: begin
        if (dec_undef) begin
          // pc is left pointing at the offending instruction
          fault_d = 1'b1;
          state_d = StFault;
        end else if (dec_is_branch && branch_taken) begin
          pc_d      = pc_br;
          retired_d = retired_q + 32'd1;
          state_d   = after_retire;
        end else if (dec_is_load || dec_is_store) begin
          mem_start = 1'b1;
          state_d   = StMem;
        end else begin
          // A not-taken branch writes nothing
          reg_we    = dec_writes_reg && !dec_is_branch;
          flags_we  = dec_sets_flags && !dec_is_branch;
          pc_d      = pc_seq;
          retired_d = retired_q + 32'd1;
          state_d   = after_retire;
        end
      end
      StMem: begin
        // A mem_done coinciding with mem_start was seen in StExecute and is ignored
        if (mem_done) begin
          reg_we    = dec_is_load;
          pc_d      = pc_seq;
          retired_d = retired_q + 32'd1;
          state_d   = after_retire;
        end
      end
      StFault: begin
        fault_d = 1'b1;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      instr_q   <= 16'h0000;
      retired_q <= 32'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      fault_q   <= fault_d;
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit Thumb-subset core. It owns the PC and fetches halfword instructions over a req/ack handshake, then holds each instruction in an instruction register that drives the Decode block. It also sequences execute, memory and writeback cycles. It applies branch redirects, stalls on data-memory access and latches a sticky fault on undefined encodings.

Parameters:
ADDR_W, 32, width of PC and instruction address
RESET_PC, 0, PC value loaded on reset (must be even)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  level; leaving IDLE requires run=1
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_W  fetch address (= pc)
imem_ack  in  1  fetch data valid this cycle
imem_rdata  in  16  fetched instruction
instruction  out  16  instruction register, feeds Decode
dec_undef  in  1  Decode: encoding unsupported
dec_is_branch  in  1  Decode: B or Bcc
branch_taken  in  1  condition evaluation result (1 for B)
dec_num  in  32  Decode immediate, sign-extended halfword offset for branches
dec_is_load  in  1  Decode: LDR
dec_is_store  in  1  Decode: STR
dec_writes_reg  in  1  Decode: op writes sel_in register
dec_sets_flags  in  1  Decode: op updates NZCV (ADD/SUB/CMP/EOR/LSL/MOV imm)
mem_start  out  1  one-cycle data-memory start pulse
mem_done  in  1  data-memory access complete
reg_we  out  1  register-file write enable
flags_we  out  1  flags write enable
pc  out  ADDR_W  current PC
fault  out  1  sticky undefined-instruction fault
retired  out  32  retired-instruction counter

Behaviour:
- Reset (async, immediate):
  - state=IDLE, pc=RESET_PC, instruction=16'h0000, retired=0, fault=0.
  - imem_req, mem_start, reg_we and flags_we all 0.
  - Reset in any state aborts the operation in flight. A late imem_ack or mem_done arriving after reset is ignored.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, FAULT.
- IDLE: outputs inactive. Next cycle goes to FETCH when run=1.
- FETCH:
  - imem_req=1, imem_addr=pc, both held stable until imem_ack sampled 1.
  - On the ack edge: instruction<=imem_rdata, go to DECODE.
  - Zero-wait ack means FETCH lasts 1 cycle.
- DECODE: one cycle so the Decode outputs settle from the instruction register. No outputs asserted.
- EXECUTE (one cycle), priority order:
  1. dec_undef: no writes, fault<=1, go to FAULT. pc and retired are unchanged; pc still addresses the bad instruction.
  2. dec_is_branch & branch_taken: pc<=pc+4+(dec_num<<1), truncated to ADDR_W (wraps modulo 2^ADDR_W). No reg_we, no flags_we. retired++ and go to FETCH (when run=0, go to IDLE instead).
  3. dec_is_load|dec_is_store: mem_start=1 this cycle, go to MEM.
  4. Otherwise:
     - reg_we=dec_writes_reg; flags_we=dec_sets_flags.
     - A not-taken branch asserts neither.
     - pc<=pc+2, retired++; go to FETCH (when run=0, go to IDLE instead).
- MEM:
  - Wait for mem_done; mem_start is not reasserted.
  - In the cycle mem_done=1: reg_we=dec_is_load; pc<=pc+2; retired++; go to FETCH (when run=0, go to IDLE instead).
  - If mem_done arrives in the same cycle as mem_start (EXECUTE), it is ignored; MEM requires a fresh mem_done.
- FAULT: absorbing. Only reset exits. All strobes 0, fault=1.
- run is sampled only in IDLE and at instruction completion; deasserting run mid-instruction lets the instruction finish.
- reg_we, flags_we and mem_start are never high outside the cycles listed above, and never for more than one cycle per instruction.
- pc is always even.
- Cycle cost (zero-wait fetch):
  - ALU op or branch: 3 cycles.
  - LDR/STR: 3 + N cycles, where N≥1 is the mem_done wait.

Decomposition:
- Shared package: state encoding constants (IDLE..FAULT), PC increment (2), branch pipeline offset (4). Decode's uop encodings already live in the same package.
- The block is a single module, with no sub-module.
- The branch-target adder stays inline; it is a single expression.

Test Plan:
1. Reset then run=1, RESET_PC=0, imem_ack with 0 wait states, stream ADD 16'h192E, MOV 16'h24D5, SUB 16'h3BE2:
   - imem_addr 0,2,4, one fetch every 3 cycles.
   - reg_we=1 and flags_we=1 in each EXECUTE.
   - retired=3, pc=6.
2. Fetch with 3-cycle ack delay: imem_req held 4 cycles with imem_addr constant. instruction updates only on the ack edge.
3. pc=0x1000, B with dec_num=-1005, branch_taken=1: next imem_addr=0x82A, no reg_we or flags_we, retired+1.
4. LDR 16'h6911 with mem_done 2 cycles after mem_start: mem_start exactly one cycle; reg_we only in the mem_done cycle; next fetch at pc+2. Repeat with STR 16'h65FE: reg_we stays 0.
5. Undefined 16'hE800 at pc=0x10 (dec_undef=1): fault=1, pc stays 0x10, no further imem_req for 20 cycles, retired unchanged.
6. Assert reset mid-MEM while mem_done is pending: immediate return to IDLE with all reset values. A later mem_done pulse causes no reg_we.
